// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive slice: frame geometry, the
// minimum usable clock divisor and the receiver FSM state encoding.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if
// Write-side connection between the UART receiver and its receive FIFO.
//   data_o      : received byte, valid with we_o
//   we_o        : one-cycle FIFO write strobe
//   frame_err_o : one-cycle pulse, stop bit sampled low
//   overrun_o   : one-cycle pulse, good byte dropped because FIFO full
//   full_i      : FIFO full flag back to the receiver
// master = receiver side, slave = FIFO side.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_o;
  logic                 we_o;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 full_i;

  modport master (
    output data_o, we_o, frame_err_o, overrun_o,
    input  full_i
  );

  modport slave (
    input  data_o, we_o, frame_err_o, overrun_o,
    output full_i
  );

endinterface

// File: rtl/sync_ff.sv
// sync_ff
// Multi-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, all stages load RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, DEPTH cycles behind d
module sync_ff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  // Plain shift chain; the idle-high reset value keeps a reset from
  // looking like a start-bit edge on the serial line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {DEPTH{RESET_VAL}};
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
// Receive front end of the UART: synchronises rx, validates start bits,
// deserialises 8N1 frames LSB first and pushes good bytes into the FIFO.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   rx_en  : receiver enable, low forces IDLE and drops any partial frame
//   baud   : clock cycles per bit, values below 2 behave as 2
//   rx     : asynchronous serial input, idle high
//   busy_o : high while the receiver is not IDLE
//   fifo   : FIFO write port (data, strobe, error pulses, full flag)
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud,
  input  logic             rx,
  output logic             busy_o,
  uart_rx_frame_if.master  fifo
);

  logic                 rx_s;
  logic                 rx_d;
  logic                 fall;
  logic [DIV_W-1:0]     n_cur;
  logic [DIV_W-1:0]     h_cur;
  logic [DIV_W-1:0]     n_reg;
  logic [DIV_W-1:0]     h_reg;
  logic [DIV_W-1:0]     n_last;
  logic [DIV_W-1:0]     h_last;
  logic [DIV_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  rx_state_t            state;

  sync_ff #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // One-cycle delayed copy of the synchronised line for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d <= 1'b1;
    end else begin
      rx_d <= rx_s;
    end
  end

  assign fall   = rx_d & ~rx_s;
  assign n_cur  = (baud < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud;
  assign h_cur  = n_cur >> 1;
  assign n_last = n_reg - DIV_W'(1);
  assign h_last = h_reg - DIV_W'(1);

  // Receiver FSM. The divisor is latched at start detection so a baud
  // change mid-frame only takes effect on the next frame. STOP returns
  // to IDLE at mid-stop-bit so a back-to-back start edge is not missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      bit_idx          <= 3'd0;
      shreg            <= '0;
      n_reg            <= DIV_W'(MIN_DIV);
      h_reg            <= DIV_W'(MIN_DIV / 2);
      busy_o           <= 1'b0;
      fifo.data_o      <= '0;
      fifo.we_o        <= 1'b0;
      fifo.frame_err_o <= 1'b0;
      fifo.overrun_o   <= 1'b0;
    end else begin
      fifo.we_o        <= 1'b0;
      fifo.frame_err_o <= 1'b0;
      fifo.overrun_o   <= 1'b0;
      if (!rx_en) begin
        state  <= IDLE;
        cnt    <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state  <= START;
              cnt    <= '0;
              n_reg  <= n_cur;
              h_reg  <= h_cur;
              busy_o <= 1'b1;
            end
          end
          START: begin
            if (cnt == h_last) begin
              cnt <= '0;
              if (!rx_s) begin
                state   <= DATA;
                bit_idx <= 3'd0;
              end else begin
                // Line is back high at mid-start-bit: treat as a glitch.
                state  <= IDLE;
                busy_o <= 1'b0;
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          DATA: begin
            if (cnt == n_last) begin
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
              cnt     <= '0;
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'(DATA_BITS - 1)) begin
                state <= STOP;
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          STOP: begin
            if (cnt == n_last) begin
              state  <= IDLE;
              cnt    <= '0;
              busy_o <= 1'b0;
              if (rx_s) begin
                if (!fifo.full_i) begin
                  fifo.data_o <= shreg;
                  fifo.we_o   <= 1'b1;
                end else begin
                  fifo.overrun_o <= 1'b1;
                end
              end else begin
                fifo.frame_err_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
// Directed bench for uart_rx_frame. Each stimulus task announces, at the
// moment it starts driving a frame, the absolute cycle at which the
// receiver must pulse and the interval during which it must be busy.
// A negedge process compares every cycle against those announcements,
// and a few literal expectations pin latency, spacing and data values.
module tb_uart_rx_frame;

  localparam int DIV_W = 32;

  logic             clk;
  logic             rst_n;
  logic             rx_en;
  logic             rx;
  logic             busy_o;
  logic [DIV_W-1:0] baud;

  uart_rx_frame_if fifo_if ();

  uart_rx_frame #(
    .SYNC_STAGES (2),
    .DIV_W       (DIV_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_en  (rx_en),
    .baud   (baud),
    .rx     (rx),
    .busy_o (busy_o),
    .fifo   (fifo_if)
  );

  typedef enum int {EV_WE, EV_FE, EV_OVR} ev_kind_t;
  typedef struct {
    int         at;
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;
  typedef struct {
    int lo;
    int hi;
  } win_t;

  ev_t        evq[$];
  win_t       busyq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_data = 8'h00;
  int         we_cnt = 0;
  int         fe_cnt = 0;
  int         ovr_cnt = 0;
  int         busy_cycles = 0;
  int         busy_rise = 0;
  logic       busy_prev = 1'b0;
  int         last_we_cyc = 0;
  logic [7:0] last_we_data = 8'h00;
  int         we_hist[$];
  logic [7:0] data_hist[$];

  // Free-running clock and absolute cycle index (edges seen so far).
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Per-cycle comparison against the announced events and busy windows,
  // plus a monitor that records what the DUT actually emitted.
  always @(negedge clk) begin : compare
    logic       e_we, e_fe, e_ovr, e_busy;
    logic [7:0] e_d;
    e_we   = 1'b0;
    e_fe   = 1'b0;
    e_ovr  = 1'b0;
    e_busy = 1'b0;
    e_d    = exp_data;
    foreach (evq[i]) begin
      if (evq[i].at == cyc) begin
        case (evq[i].kind)
          EV_WE:   begin e_we = 1'b1; e_d = evq[i].data; end
          EV_FE:   e_fe = 1'b1;
          default: e_ovr = 1'b1;
        endcase
      end
    end
    foreach (busyq[i]) begin
      if (cyc >= busyq[i].lo && cyc <= busyq[i].hi) e_busy = 1'b1;
    end
    if (!rst_n) begin
      exp_data = 8'h00;
      e_we = 1'b0; e_fe = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
    end else if (e_we) begin
      exp_data = e_d;
    end
    check_output("we_o", fifo_if.we_o, e_we);
    check_output("frame_err_o", fifo_if.frame_err_o, e_fe);
    check_output("overrun_o", fifo_if.overrun_o, e_ovr);
    check_output("busy_o", busy_o, e_busy);
    check_output("data_o", fifo_if.data_o, exp_data);

    if (fifo_if.we_o) begin
      we_cnt++;
      last_we_cyc  = cyc;
      last_we_data = fifo_if.data_o;
      we_hist.push_back(cyc);
      data_hist.push_back(fifo_if.data_o);
    end
    if (fifo_if.frame_err_o) fe_cnt++;
    if (fifo_if.overrun_o) ovr_cnt++;
    if (busy_o) busy_cycles++;
    if (busy_o && !busy_prev) busy_rise = cyc;
    busy_prev = busy_o;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  function automatic int eff_div();
    return (baud < 2) ? 2 : int'(baud);
  endfunction

  // Drive one 8N1 frame starting now (posedge+1). mode 0 = complete frame,
  // 1 = drop rx_en after data bit 3, 2 = assert rst_n after data bit 3.
  // The pin falls after edge c0; rx_s falls 2 edges later and START is
  // entered at c0+3, so the stop sample edge is c0+3+H+9N.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit,
                                input logic full, input int mode, input int gap);
    int         n, h, c0, s;
    logic [9:0] bits;
    ev_t        ev;
    win_t       w;
    n    = eff_div();
    h    = n / 2;
    c0   = cyc;
    s    = c0 + 3 + h + 9 * n;
    bits = {stop_bit, data, 1'b0};
    fifo_if.full_i = full;
    w.lo = c0 + 3;
    if (mode == 0) begin
      w.hi    = s - 1;
      ev.at   = s;
      ev.data = data;
      ev.kind = !stop_bit ? EV_FE : (full ? EV_OVR : EV_WE);
      evq.push_back(ev);
    end else if (mode == 1) begin
      w.hi = c0 + 5 * n;
    end else begin
      w.hi = c0 + 5 * n - 1;
    end
    busyq.push_back(w);
    for (int j = 0; j < 10; j++) begin
      if (mode != 0 && j == 5) break;
      rx = bits[j];
      tick(n);
    end
    rx = 1'b1;
    if (mode == 1) begin
      rx_en = 1'b0;
      tick(4);
      rx_en = 1'b1;
    end else if (mode == 2) begin
      rst_n = 1'b0;
      #1;
      check_output("rst_busy", busy_o, 1'b0);
      check_output("rst_data", fifo_if.data_o, 8'h00);
      check_output("rst_we", fifo_if.we_o, 1'b0);
      check_output("rst_fe", fifo_if.frame_err_o, 1'b0);
      check_output("rst_ovr", fifo_if.overrun_o, 1'b0);
      tick(3);
      rst_n = 1'b1;
    end
    fifo_if.full_i = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  // Low pulse of len cycles on an idle line: the start check at H finds
  // the line high again, so only the START window is busy.
  task automatic apply_glitch(input int len);
    win_t w;
    w.lo = cyc + 3;
    w.hi = cyc + 3 + eff_div() / 2 - 1;
    busyq.push_back(w);
    rx = 1'b0;
    tick(len);
    rx = 1'b1;
    tick(40);
  endtask

  // Line held low for nbits bit times: one frame of zeros with a low stop.
  task automatic apply_break(input int nbits);
    int   n, c0;
    win_t w;
    ev_t  ev;
    n       = eff_div();
    c0      = cyc;
    w.lo    = c0 + 3;
    w.hi    = c0 + 3 + n / 2 + 9 * n - 1;
    ev.at   = w.hi + 1;
    ev.kind = EV_FE;
    ev.data = 8'h00;
    busyq.push_back(w);
    evq.push_back(ev);
    rx = 1'b0;
    tick(nbits * n);
    rx = 1'b1;
    tick(10);
  endtask

  initial begin : main
    int w0, f0, o0, b0, k;
    rst_n = 1'b1;
    rx    = 1'b1;
    rx_en = 1'b0;
    baud  = 32'd16;
    fifo_if.full_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_output("reset_data", fifo_if.data_o, 8'h00);
    check_output("reset_we", fifo_if.we_o, 1'b0);
    check_output("reset_fe", fifo_if.frame_err_o, 1'b0);
    check_output("reset_ovr", fifo_if.overrun_o, 1'b0);
    check_output("reset_busy", busy_o, 1'b0);
    tick(3);
    rst_n = 1'b1;
    rx_en = 1'b1;
    tick(5);

    $display("[TB] single byte 0xA5");
    w0 = we_cnt; f0 = fe_cnt; o0 = ovr_cnt;
    apply_stimulus(8'hA5, 1'b1, 1'b0, 0, 4);
    tick(10);
    check_output("a5_count", we_cnt - w0, 1);
    check_output("a5_data", last_we_data, 8'hA5);
    check_output("a5_latency", last_we_cyc - busy_rise, 152);
    check_output("a5_noerr", (fe_cnt - f0) + (ovr_cnt - o0), 0);

    $display("[TB] back-to-back 0x00 0xFF 0x55");
    k = we_hist.size();
    apply_stimulus(8'h00, 1'b1, 1'b0, 0, 0);
    apply_stimulus(8'hFF, 1'b1, 1'b0, 0, 0);
    apply_stimulus(8'h55, 1'b1, 1'b0, 0, 4);
    tick(10);
    check_output("b2b_count", we_hist.size() - k, 3);
    if (we_hist.size() >= k + 3) begin
      check_output("b2b_gap1", we_hist[k+1] - we_hist[k], 160);
      check_output("b2b_gap2", we_hist[k+2] - we_hist[k+1], 160);
      check_output("b2b_d0", data_hist[k], 8'h00);
      check_output("b2b_d1", data_hist[k+1], 8'hFF);
      check_output("b2b_d2", data_hist[k+2], 8'h55);
    end

    $display("[TB] glitch rejection");
    w0 = we_cnt; f0 = fe_cnt; o0 = ovr_cnt; b0 = busy_cycles;
    apply_glitch(3);
    check_output("glitch_busy", busy_cycles - b0, 8);
    check_output("glitch_pulses", (we_cnt - w0) + (fe_cnt - f0) + (ovr_cnt - o0), 0);

    $display("[TB] stop bit low");
    w0 = we_cnt; f0 = fe_cnt;
    apply_stimulus(8'h3C, 1'b0, 1'b0, 0, 4);
    tick(10);
    check_output("ferr_count", fe_cnt - f0, 1);
    check_output("ferr_nowe", we_cnt - w0, 0);
    check_output("ferr_hold", fifo_if.data_o, 8'h55);

    $display("[TB] break");
    w0 = we_cnt; f0 = fe_cnt;
    apply_break(40);
    check_output("break_fe", fe_cnt - f0, 1);
    check_output("break_nowe", we_cnt - w0, 0);

    $display("[TB] overrun then release");
    w0 = we_cnt; o0 = ovr_cnt;
    apply_stimulus(8'h7E, 1'b1, 1'b1, 0, 4);
    tick(10);
    check_output("ovr_count", ovr_cnt - o0, 1);
    check_output("ovr_nowe", we_cnt - w0, 0);
    check_output("ovr_hold", fifo_if.data_o, 8'h55);
    apply_stimulus(8'h7E, 1'b1, 1'b0, 0, 4);
    tick(10);
    check_output("release_we", we_cnt - w0, 1);
    check_output("release_data", last_we_data, 8'h7E);

    $display("[TB] rx_en abort");
    w0 = we_cnt; f0 = fe_cnt; o0 = ovr_cnt;
    apply_stimulus(8'h96, 1'b1, 1'b0, 1, 0);
    tick(200);
    check_output("abort_pulses", (we_cnt - w0) + (fe_cnt - f0) + (ovr_cnt - o0), 0);
    check_output("abort_idle", busy_o, 1'b0);

    $display("[TB] reset abort");
    w0 = we_cnt;
    apply_stimulus(8'h69, 1'b1, 1'b0, 2, 0);
    tick(200);
    check_output("rst_abort_nowe", we_cnt - w0, 0);
    apply_stimulus(8'hE1, 1'b1, 1'b0, 0, 4);
    tick(10);
    check_output("post_rst_data", last_we_data, 8'hE1);

    $display("[TB] small divisors");
    baud = 32'd0;
    apply_stimulus(8'h5A, 1'b1, 1'b0, 0, 4);
    tick(10);
    check_output("baud0_data", last_we_data, 8'h5A);
    baud = 32'd1;
    w0 = we_cnt;
    apply_stimulus(8'hC3, 1'b1, 1'b0, 0, 4);
    tick(10);
    check_output("baud1_data", last_we_data, 8'hC3);
    check_output("baud1_count", we_cnt - w0, 1);

    tick(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
